// File: rtl/integrator_comb_decim_if.sv
// Signal bundle between the integrator comb/decimator and its neighbours.
// drop_cnt exists only when INTEGRATOR_COMB_DECIM_DROP_CNT_EN is defined.
interface integrator_comb_decim_if #(
    parameter int WIDTH = 10
);
    logic signed [WIDTH-1:0] eta_i1;
    logic signed [WIDTH-1:0] bodyVar_o;
    logic                    out_valid;
    logic                    out_ready;
    logic                    drop_flag;
`ifdef INTEGRATOR_COMB_DECIM_DROP_CNT_EN
    logic [7:0]              drop_cnt;

    modport master (
        input  eta_i1, out_ready,
        output bodyVar_o, out_valid, drop_flag, drop_cnt
    );
    modport slave (
        output eta_i1, out_ready,
        input  bodyVar_o, out_valid, drop_flag, drop_cnt
    );
`else
    modport master (
        input  eta_i1, out_ready,
        output bodyVar_o, out_valid, drop_flag
    );
    modport slave (
        output eta_i1, out_ready,
        input  bodyVar_o, out_valid, drop_flag
    );
`endif
endinterface

// File: rtl/integrator_comb_decim.sv
// Decimate-by-DECIM comb stage with a single-entry valid/ready output register.
// Optional drop counter: define INTEGRATOR_COMB_DECIM_DROP_CNT_EN.
module integrator_comb_decim #(
    parameter int WIDTH = 10,
    parameter int DECIM = 4,
    parameter int CNT_W = 8
) (
    input logic                    system1000,
    input logic                    system1000_rstn,
    integrator_comb_decim_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]        cnt;
    logic signed [WIDTH-1:0] prev;
    logic signed [WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    drop_q;
    logic                    tick;
    logic                    accept;
    logic [WIDTH:0]          diff_wide;
    logic signed [WIDTH-1:0] diff;

    assign tick   = (cnt == LAST_CNT);
    assign accept = !valid_q || bus.out_ready;

    // Overflow of the WIDTH+1-bit difference shows as disagreeing top two bits.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        diff_wide = {bus.eta_i1[WIDTH-1], bus.eta_i1} - {prev[WIDTH-1], prev};
        diff      = diff_wide[WIDTH-1:0];
        if (diff_wide[WIDTH] != diff_wide[WIDTH-1]) begin
            diff = diff_wide[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            cnt     <= '0;
            prev    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                prev <= bus.eta_i1;
            end
            if (tick && accept) begin
                data_q  <= diff;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (tick && !accept) begin
                drop_q <= 1'b1;
            end
        end
    end

`ifdef INTEGRATOR_COMB_DECIM_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            drop_cnt_q <= '0;
        end else if (tick && !accept && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.bodyVar_o = data_q;
    assign bus.out_valid = valid_q;
    assign bus.drop_flag = drop_q;

endmodule

// File: tb/tb_integrator_comb_decim.sv
// Randomized scoreboard bench for integrator_comb_decim against a plain-arithmetic model.
module tb_integrator_comb_decim;

    localparam int WIDTH = 10;
    localparam int DECIM = 4;
    localparam int CNT_W = 8;
    localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN  = -(1 << (WIDTH - 1));

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    integrator_comb_decim_if #(.WIDTH(WIDTH)) bus ();

    integrator_comb_decim #(.WIDTH(WIDTH), .DECIM(DECIM), .CNT_W(CNT_W)) dut (
        .system1000     (clk),
        .system1000_rstn(rstn),
        .bus            (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a result is produced on every DECIM-th edge after reset
    // release, held in a one-deep buffer, and discarded if the buffer is still full.
    int exp_q[$];
    bit m_valid, m_drop, m_started, m_just_reset;
    int m_prev, m_dcnt, m_edges;

    function automatic int sat(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    always @(posedge clk) begin
        int eta;
        bit rdy;
        if (!rstn) begin
            m_valid = 0; m_drop = 0; m_prev = 0; m_dcnt = 0; m_edges = 0;
            exp_q.delete();
            m_started = 1; m_just_reset = 1;
        end else begin
            m_just_reset = 0;
            m_edges++;
            eta = int'(bus.eta_i1);
            rdy = bus.out_ready;
            if (m_edges % DECIM == 0) begin
                if (!m_valid || rdy) begin
                    exp_q.push_back(sat(eta - m_prev));
                    m_valid = 1;
                end else begin
                    m_drop = 1;
                    if (m_dcnt < 255) m_dcnt++;
                end
                m_prev = eta;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: samples on the falling edge, retires the front entry on handshake.
    always @(negedge clk) begin
        if (m_started) begin
            if (m_just_reset) check("reset_data", int'(bus.bodyVar_o), 0);
            check("valid", int'(bus.out_valid), int'(m_valid));
            check("drop_flag", int'(bus.drop_flag), int'(m_drop));
`ifdef INTEGRATOR_COMB_DECIM_DROP_CNT_EN
            check("drop_cnt", int'(bus.drop_cnt), m_dcnt);
`endif
            if (m_valid && exp_q.size() > 0) begin
                check("data", int'(bus.bodyVar_o), exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int eta, input bit rdy);
        bus.eta_i1    = WIDTH'(eta);
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        rstn = 1'b0;
        repeat (edges) step(0, 1'b1);
        rstn = 1'b1;
    endtask

    initial begin
        bus.eta_i1    = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Constant input: first result 5, then zeros.
        do_reset(2);
        for (int i = 0; i < 20; i++) step(5, 1'b1);

        // Ramp from reset release: 3, 4, 4, 4.
        do_reset(1);
        for (int i = 0; i < 20; i++) step(i, 1'b1);

        // Saturation: ticks sample 511, -512, 511.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(511, 1'b1);
        for (int i = 0; i < 4; i++) step(-512, 1'b1);
        for (int i = 0; i < 8; i++) step(511, 1'b1);

        // Backpressure for 12 cycles, then drain with a tick-coincident transfer.
        do_reset(1);
        for (int i = 0; i < 12; i++) step(i * 7 - 40, 1'b0);
        for (int i = 0; i < 3; i++) step(100, 1'b1);
        step(-100, 1'b0);
        for (int i = 0; i < 8; i++) step(i * 30, (i % 4) == 0);
        for (int i = 0; i < 8; i++) step(3, 1'b1);

        // Reset mid-operation with a result pending and cnt == 2.
        do_reset(1);
        for (int i = 0; i < 6; i++) step(50, 1'b0);
        do_reset(1);
        for (int i = 0; i < 10; i++) step(-77, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rstn = 1'b0;
            else rstn = 1'b1;
            step(int'($urandom_range(0, 1023)) - 512, $urandom_range(0, 1) == 1);
        end
        rstn = 1'b1;

`ifdef INTEGRATOR_COMB_DECIM_DROP_CNT_EN
        // Hold off the consumer for 300 ticks to saturate the drop counter.
        do_reset(1);
        for (int i = 0; i < 300 * DECIM; i++) step(int'($urandom_range(0, 1023)) - 512, 1'b0);
        for (int i = 0; i < 8; i++) step(1, 1'b1);
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1, 1'b1);
`endif

        for (int i = 0; i < 12; i++) step(0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
